aes_encrypt: RTL and testbench

- Low-area AES-128 encryption core with a byte-serial interface.
- Accepts a 128-bit key and a 128-bit plaintext as 16 byte pairs, most significant byte first, on consecutive clocks.
- Runs the 10 AES rounds iteratively with on-the-fly key expansion, then streams the 16 ciphertext bytes out with a valid flag.
- Leaf block of the crypto datapath; no back-pressure.

---
 rtl/aes_encrypt.sv | 141 ++++++++++++++
 tb/tb_aes_encrypt.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt.sv
// AES-128 encryption core: byte-serial load, one full round per clock with on-the-fly
// key expansion, then a byte-serial ciphertext burst qualified by valid.
module aes_encrypt (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic [7:0] datain,
    output logic [7:0] dataout,
    output logic       valid
);
    typedef enum logic [1:0] {LOAD = 2'd0, ROUND = 2'd1, OUTPUT = 2'd2} fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    fsm_e         fsm_q;
    logic [3:0]   cnt_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [7:0]   dout_q;
    logic         valid_q;

    logic [127:0] sb, sr, mc, state_d, key_d;
    logic [31:0]  temp, n0, n1, n2, n3;
    logic [7:0]   rcon;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of a 128-bit word sits at [127-8k -: 8]; byte k is row k%4, column k/4.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int k = 0; k < 16; k++) sb[127-8*k -: 8] = SBOX[state_q[127-8*k -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[127-8*(4*c+r) -: 8] = xt(sr[127-8*(4*c+r) -: 8])
                                       ^ xt(sr[127-8*(4*c+(r+1)%4) -: 8])
                                       ^ sr[127-8*(4*c+(r+1)%4) -: 8]
                                       ^ sr[127-8*(4*c+(r+2)%4) -: 8]
                                       ^ sr[127-8*(4*c+(r+3)%4) -: 8];
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        temp = {SBOX[key_q[23:16]], SBOX[key_q[15:8]], SBOX[key_q[7:0]], SBOX[key_q[31:24]]}
             ^ {rcon, 24'h000000};
        n0 = key_q[127:96] ^ temp;
        n1 = key_q[95:64] ^ n0;
        n2 = key_q[63:32] ^ n1;
        n3 = key_q[31:0] ^ n2;
        key_d = {n0, n1, n2, n3};
        // Final round omits MixColumns.
        state_d = ((round_q == 4'd9) ? sr : mc) ^ key_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= LOAD;
            cnt_q   <= 4'd0;
            round_q <= 4'd0;
            state_q <= '0;
            key_q   <= '0;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                LOAD: begin
                    state_q <= {state_q[119:0], datain ^ key};
                    key_q   <= {key_q[119:0], key};
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        fsm_q   <= ROUND;
                        round_q <= 4'd0;
                    end
                end
                ROUND: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'd9) begin
                        fsm_q   <= OUTPUT;
                        cnt_q   <= 4'd0;
                        valid_q <= 1'b1;
                        dout_q  <= state_d[127:120];
                    end
                end
                OUTPUT: begin
                    // state_q shifts left so the next byte to present is always at [119:112].
                    if (cnt_q == 4'd15) begin
                        fsm_q   <= LOAD;
                        cnt_q   <= 4'd0;
                        round_q <= 4'd0;
                        valid_q <= 1'b0;
                        dout_q  <= 8'h00;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        dout_q  <= state_q[119:112];
                        state_q <= {state_q[119:0], 8'h00};
                    end
                end
                default: fsm_q <= LOAD;
            endcase
        end
    end

    assign dataout = dout_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Bench for aes_encrypt: known-answer table, random blocks against a reference AES model,
// back-to-back bursts, and resets mid-round and mid-output.
module tb_aes_encrypt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key = 8'h00;
    logic [7:0] datain = 8'h00;
    logic [7:0] dataout;
    logic       valid;

    aes_encrypt dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .datain  (datain),
        .dataout (dataout),
        .valid   (valid)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    int unsigned rise_q[$];
    logic [7:0]  sbox_tab[256];

    typedef struct {
        logic [127:0] k;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs[3];

    localparam logic [127:0] APPB_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_CT = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box built from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rd < 10)
                        s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                 ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) out[127-8*b -: 8] = s[b];
        return out;
    endfunction

    // ---------------- driver tasks (entered #1 after a rising edge) ----------------
    task automatic load_bytes(input logic [127:0] k, input logic [127:0] pt);
        rise_q.push_back(cyc);
        rst = 1'b1;
        for (int b = 0; b < 16; b++) begin
            key    = k[127-8*b -: 8];
            datain = pt[127-8*b -: 8];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic garbage(input int n);
        repeat (n) begin
            key    = 8'($urandom);
            datain = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [127:0] ct, input int nbytes);
        for (int b = 0; b < nbytes; b++) exp_q.push_back(ct[127-8*b -: 8]);
    endtask

    // Full 42-cycle block: 16 load edges then 26 edges of garbage through rounds and output.
    task automatic send_block(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ct);
        push_exp(ct, 16);
        load_bytes(k, pt);
        garbage(26);
    endtask

    task automatic apply_reset(input string name);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 128'(valid), 128'(0));
        check({name, "_dout"}, 128'(dataout), 128'(0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          pv;
        bit          hb;
        int          bl;
        int          lr;
        int unsigned e;
        pv = 1'b0;
        hb = 1'b0;
        bl = 0;
        lr = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (valid === 1'b1) begin
                    if (!pv) begin
                        if (rise_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL rise_unexpected: valid rose after edge %0d, expected no burst", cyc - 1);
                        end else begin
                            e = rise_q.pop_front();
                            check("rise_latency", 128'(cyc - 1), 128'(e + 25));
                        end
                        if (hb) check("gap_len", 128'(lr), 128'(26));
                    end
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ct_unexpected: got byte %0h, expected none", dataout);
                    end else begin
                        check("ct_byte", 128'(dataout), 128'(exp_q.pop_front()));
                    end
                    bl++;
                end else begin
                    check("idle_out", 128'({valid, dataout}), 128'(0));
                    if (pv) begin
                        check("burst_len", 128'(bl), 128'(16));
                        hb = 1'b1;
                        lr = 1;
                        bl = 0;
                    end else begin
                        lr++;
                    end
                end
                pv = (valid === 1'b1);
                if (rst === 1'b0) begin
                    pv = 1'b0;
                    hb = 1'b0;
                    bl = 0;
                    lr = 0;
                    exp_q.delete();
                    rise_q.delete();
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] rk;
        logic [127:0] rp;

        vecs[0] = '{APPB_K, APPB_PT, APPB_CT};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 128'(valid), 128'(0));
        check("reset_dout", 128'(dataout), 128'(0));
        mon_en = 1'b1;

        // Known answers followed directly by random blocks, all back-to-back.
        for (int i = 0; i < 3; i++) send_block(vecs[i].k, vecs[i].pt, vecs[i].ct);
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            send_block(rk, rp, aes_ref(rk, rp));
        end
        check("drain_exp", 128'(exp_q.size()), 128'(0));
        check("drain_rise", 128'(rise_q.size()), 128'(0));
        apply_reset("idle_rst");

        // Reset at edge 20 of a block (mid-round): nothing may come out.
        load_bytes(APPB_K, APPB_PT);
        garbage(4);
        apply_reset("midround_rst");
        send_block(APPB_K, APPB_PT, APPB_CT);

        // Reset during the third valid cycle (mid-output): only bytes 0..2 appear.
        push_exp(APPB_CT, 3);
        load_bytes(APPB_K, APPB_PT);
        garbage(12);
        apply_reset("midout_rst");
        check("midout_flushed", 128'(exp_q.size()), 128'(0));

        send_block(APPB_K, APPB_PT, APPB_CT);
        check("final_exp", 128'(exp_q.size()), 128'(0));
        check("final_rise", 128'(rise_q.size()), 128'(0));
        apply_reset("end_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
